// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Define BCD_BIN_OUT_EN to add the serially built binary result port out_bin.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIGITS*4-1:0]   in_a,
    input  logic [DIGITS*4-1:0]   in_b,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGITS*4-1:0]   out_sum,
    output logic                  out_carry,
`ifdef BCD_BIN_OUT_EN
    output logic [DIGITS*4:0]     out_bin,
`endif
    output logic                  out_err
);
    localparam int W  = DIGITS * 4;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            sub_q, sub_d, err_q, err_d, c_q, c_d;
    logic            carry_q, carry_d, eout_q, eout_d;

    logic [3:0]      ak, bk, bp, dig;
    logic [4:0]      s, s10;
    logic            cout, last;
    logic [W-1:0]    res_n;

`ifdef BCD_BIN_OUT_EN
    logic [W:0]      wt_q, wt_d, acc_q, acc_d, bin_q, bin_d;
    logic [W:0]      wt10, acc_n;
`endif

    function automatic logic has_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    // Digit slice: subtraction adds the nine's complement plus initial carry.
    always_comb begin
        ak   = a_q[4*int'(cnt_q) +: 4];
        bk   = b_q[4*int'(cnt_q) +: 4];
        bp   = sub_q ? (4'd9 - bk) : bk;
        s    = {1'b0, ak} + {1'b0, bp} + {4'd0, c_q};
        s10  = s - 5'd10;
        cout = (s > 5'd9);
        dig  = cout ? s10[3:0] : s[3:0];
        last = (cnt_q == CW'(DIGITS - 1));
        res_n = res_q;
        res_n[4*int'(cnt_q) +: 4] = dig;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        err_d   = err_q;
        c_d     = c_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        eout_d  = eout_q;
`ifdef BCD_BIN_OUT_EN
        wt10  = (wt_q << 3) + (wt_q << 1);
        acc_n = acc_q + ((W+1)'(dig) * wt_q);
        wt_d  = wt_q;
        acc_d = acc_q;
        bin_d = bin_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = in_sub;
                    err_d   = has_bad(in_a) | has_bad(in_b);
                    c_d     = in_sub;
                    res_d   = '0;
                    cnt_d   = '0;
`ifdef BCD_BIN_OUT_EN
                    wt_d  = (W+1)'(1);
                    acc_d = '0;
`endif
                end
            end
            RUN: begin
                res_d = res_n;
                c_d   = cout;
                cnt_d = CW'(cnt_q + 1'b1);
`ifdef BCD_BIN_OUT_EN
                acc_d = acc_n;
                wt_d  = wt10;
`endif
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    eout_d  = err_q;
                    sum_d   = err_q ? '0 : res_n;
                    carry_d = err_q ? 1'b0 : (sub_q ? ~cout : cout);
`ifdef BCD_BIN_OUT_EN
                    bin_d = err_q ? '0 :
                            acc_n + ((!sub_q && cout) ? wt10 : '0);
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            err_q   <= 1'b0;
            c_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            eout_q  <= 1'b0;
`ifdef BCD_BIN_OUT_EN
            wt_q  <= '0;
            acc_q <= '0;
            bin_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            err_q   <= err_d;
            c_q     <= c_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            eout_q  <= eout_d;
`ifdef BCD_BIN_OUT_EN
            wt_q  <= wt_d;
            acc_q <= acc_d;
            bin_q <= bin_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_err   = eout_q;
`ifdef BCD_BIN_OUT_EN
    assign out_bin   = bin_q;
`endif

endmodule
